vc_writeback_buffer: RTL and testbench
======================================

# vc_writeback_buffer

Write-back buffer directly downstream of the victim cache. It takes dirty 256-bit lines evicted from the victim cache and queues them in a small FIFO. Each queued line drains to physical memory as a 4-beat, 64-bit write burst. While a line is waiting or draining, the L1 and victim-cache miss path can look it up by address and forward it, so read misses never return stale data from memory.

## Interface
Parameters:
- DEPTH, 4: number of line entries; power of two, ≥2.
- ADDR_W, 32: address width.
- LINE_W, 256: line width; the burst is LINE_W/64 beats (4 at default).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- wb_push  in  1  victim cache presents a dirty evicted line.
- wb_addr  in  ADDR_W  address of the evicted line.
- wb_line  in  LINE_W  data of the evicted line.
- wb_full  out  1  buffer full; a push is not accepted.
- lk_addr  in  ADDR_W  miss-path lookup address.
- lk_hit  out  1  a valid entry matches lk_addr (combinational).
- lk_line  out  LINE_W  data of the matching entry; 0 when there is no hit.
- drain_hold  in  1  memory arbiter blocks the start of a new burst.
- pmem_write  out  1  write-burst request to memory.
- pmem_address  out  ADDR_W  burst base address, with bits [4:0] forced to 0.
- pmem_wdata  out  64  current burst beat.
- pmem_resp  in  1  memory accepted the current beat.
- wb_empty  out  1  no valid entries.

## Operation
- Storage is a circular FIFO with head pointer, tail pointer and count (width clog2(DEPTH)+1). Pointers wrap modulo DEPTH.
- Push: when wb_push=1 and wb_full=0, the entry at tail is written and becomes valid. Tail and count both increment.
- Push rejected: when wb_push=1 and wb_full=1, the push is ignored. The victim cache must hold wb_push until wb_full falls.
- wb_full is count==DEPTH, taken from registered state only. A pop in the same cycle does not admit a push when the buffer is full.
- Address match compares bits [ADDR_W-1:5] only.
- Lookup: every valid entry is checked, including the one currently draining.
  - If several entries match, the youngest one (closest to tail) wins.
- Drain FSM has two states, IDLE and BURST.
  - IDLE → BURST when count>0 and drain_hold=0. The beat counter is cleared to 0.
  - In BURST, pmem_write=1, pmem_address=head line address, and pmem_wdata=line[64*beat+63 : 64*beat] (beat 0 is the LSBs).
  - Each pmem_resp advances the beat. A pmem_resp on the last beat pops the head (head++, count--) and returns the FSM to IDLE.
  - drain_hold has no effect once a burst has started.
- Simultaneous push and pop: count is unchanged, both pointers advance, and the buffer stays consistent.
- Outputs in IDLE: pmem_write=0, pmem_address=0, pmem_wdata=0.

## Timing
- Reset values:
  - FSM in IDLE; count, head, tail and beat all 0; all entries invalid.
  - wb_full=0, wb_empty=1, pmem_write=0, pmem_address=0, pmem_wdata=0, lk_hit=0, lk_line=0.
- Reset asserted mid-burst aborts the burst immediately (asynchronous), and every queued line is discarded.
- A pushed line is visible to lookup, and counted, from the cycle after the accepting edge.
- Earliest burst start: pmem_write rises one cycle after the push edge.
- Best-case drain of one line: 1 cycle to enter BURST, then 4 beats at one pmem_resp per cycle.
- After a pop, the FSM spends at least one IDLE cycle before the next burst starts.
- A popped entry stops hitting on lookup in the cycle after its final pmem_resp edge.

## Configuration
- Macro: VC_WB_COALESCE_EN.
- Defined:
  - A push whose address matches a valid entry that is not currently draining overwrites that entry's data in place.
  - Count and tail do not change.
  - The push is accepted even when wb_full=1.
  - A push matching only the draining head allocates a new entry.
- Undefined: every accepted push allocates a new entry. Lookup's youngest-match rule keeps forwarding correct.

## Test plan
- Basic drain: reset; push addr 0x100, line = {64'h4,64'h3,64'h2,64'h1}; pmem_resp held 1.
  - pmem_write=1 one cycle later with pmem_address=0x100.
  - Beats are 1, 2, 3, 4.
  - wb_empty=1 after the 4th response.
- Full and wrap-around: drain_hold=1, then push 4 lines at 0x20, 0x40, 0x60, 0x80.
  - wb_full=1; a 5th push at 0xA0 is ignored.
  - Release drain_hold: lines drain in order 0x20..0x80.
  - Push 0xA0 is accepted after the first pop, and the tail wraps to slot 0.
- Forwarding: queue 0x40 with data D1, then look up 0x5F → lk_hit=1, lk_line=D1.
  - Look up 0x60 → lk_hit=0, lk_line=0.
  - After 0x40 drains, lookup 0x40 → lk_hit=0.
- Duplicate address:
  - Without the macro: push 0x40 D1, then 0x40 D2 → count=2, lookup returns D2.
  - With VC_WB_COALESCE_EN (head not draining): count=1, the entry holds D2, and a single burst writes D2.
- Mid-burst reset: assert rst after beat 1 of 4 → pmem_write=0 immediately, wb_empty=1, no further beats.
- Push concurrent with final pop at count=2: count stays 2, and the next burst uses the second-oldest address.

Source files
------------

// File: rtl/vc_writeback_buffer_if.sv
// Victim-cache write-back buffer bus: push side, lookup side and memory side.
// master = victim cache / miss path / memory, slave = the buffer itself.
interface vc_writeback_buffer_if #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256
);
   logic              wb_push;
   logic [ADDR_W-1:0] wb_addr;
   logic [LINE_W-1:0] wb_line;
   logic              wb_full;
   logic              wb_empty;
   logic [ADDR_W-1:0] lk_addr;
   logic              lk_hit;
   logic [LINE_W-1:0] lk_line;
   logic              drain_hold;
   logic              pmem_write;
   logic [ADDR_W-1:0] pmem_address;
   logic [63:0]       pmem_wdata;
   logic              pmem_resp;

   modport master (
      output wb_push, wb_addr, wb_line, lk_addr, drain_hold, pmem_resp,
      input  wb_full, wb_empty, lk_hit, lk_line,
      input  pmem_write, pmem_address, pmem_wdata
   );

   modport slave (
      input  wb_push, wb_addr, wb_line, lk_addr, drain_hold, pmem_resp,
      output wb_full, wb_empty, lk_hit, lk_line,
      output pmem_write, pmem_address, pmem_wdata
   );
endinterface

// File: rtl/vc_writeback_buffer.sv
// Dirty-line write-back FIFO with address-match forwarding and burst drain.
// VC_WB_COALESCE_EN: merge pushes into a matching, non-draining entry.
module vc_writeback_buffer #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256
) (
   input logic clk,
   input logic rst,
   vc_writeback_buffer_if.slave bus
);
   localparam int PW    = $clog2(DEPTH);
   localparam int CW    = PW + 1;
   localparam int BEATS = LINE_W / 64;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int TW    = ADDR_W - 5;

   typedef enum logic {IDLE, BURST} state_t;

   state_t            state_q;
   logic [BW-1:0]     beat_q;
   logic [PW-1:0]     head_q, head_d;
   logic [PW-1:0]     tail_q, tail_d;
   logic [CW-1:0]     count_q, count_d;
   logic [DEPTH-1:0]  vld_q;
   logic [TW-1:0]     tag_q  [DEPTH];
   logic [LINE_W-1:0] line_q [DEPTH];

   logic              full, last_beat, pop, alloc, coal;
   logic [PW-1:0]     coal_idx, lk_idx;
   logic [TW-1:0]     push_tag, lk_tag;
   logic              lk_hit;
   logic [LINE_W-1:0] lk_line;

   assign push_tag  = bus.wb_addr[ADDR_W-1:5];
   assign lk_tag    = bus.lk_addr[ADDR_W-1:5];
   assign full      = (count_q == CW'(DEPTH));
   assign last_beat = (beat_q == BW'(BEATS - 1));
   assign pop       = (state_q == BURST) && bus.pmem_resp && last_beat;

`ifdef VC_WB_COALESCE_EN
   logic [PW-1:0] co_idx;

   // Youngest valid entry matching the push, skipping the draining head.
   always_comb begin
      coal     = 1'b0;
      coal_idx = '0;
      co_idx   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         co_idx = head_q + PW'(i);
         if (vld_q[co_idx] && tag_q[co_idx] == push_tag &&
             !(i == 0 && state_q == BURST)) begin
            coal     = bus.wb_push;
            coal_idx = co_idx;
         end
      end
   end
`else
   assign coal     = 1'b0;
   assign coal_idx = '0;
`endif

   assign alloc   = bus.wb_push && !coal && !full;
   assign head_d  = pop   ? head_q + PW'(1) : head_q;
   assign tail_d  = alloc ? tail_q + PW'(1) : tail_q;
   assign count_d = count_q + CW'(alloc) - CW'(pop);

   // Pointers, occupancy and the IDLE/BURST drain machine.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         beat_q  <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         vld_q   <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         if (pop)   vld_q[head_q] <= 1'b0;
         if (alloc) vld_q[tail_q] <= 1'b1;
         unique case (state_q)
            IDLE: begin
               if (count_q != '0 && !bus.drain_hold) begin
                  state_q <= BURST;
                  beat_q  <= '0;
               end
            end
            BURST: begin
               if (bus.pmem_resp) begin
                  if (last_beat) state_q <= IDLE;
                  else           beat_q  <= beat_q + BW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Line storage: new entries at tail, coalesced data in place.
   always_ff @(posedge clk) begin
      if (alloc) begin
         tag_q[tail_q]  <= push_tag;
         line_q[tail_q] <= bus.wb_line;
      end else if (coal) begin
         line_q[coal_idx] <= bus.wb_line;
      end
   end

   // Forwarding lookup; scan oldest to youngest so the youngest wins.
   always_comb begin
      lk_hit  = 1'b0;
      lk_line = '0;
      lk_idx  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         lk_idx = head_q + PW'(i);
         if (vld_q[lk_idx] && tag_q[lk_idx] == lk_tag) begin
            lk_hit  = 1'b1;
            lk_line = line_q[lk_idx];
         end
      end
   end

   assign bus.lk_hit       = lk_hit;
   assign bus.lk_line      = lk_line;
   assign bus.wb_full      = full;
   assign bus.wb_empty     = (count_q == '0);
   assign bus.pmem_write   = (state_q == BURST);
   assign bus.pmem_address = (state_q == BURST) ?
                             {tag_q[head_q], 5'd0} : '0;
   assign bus.pmem_wdata   = (state_q == BURST) ?
                             line_q[head_q][{beat_q, 6'd0} +: 64] : '0;
endmodule

// File: tb/tb_vc_writeback_buffer.sv
// Self-checking bench for vc_writeback_buffer: directed scenarios plus
// randomized traffic compared each cycle against a queue-based model.
module tb_vc_writeback_buffer;
   localparam int AW = 32;
   localparam int LW = 256;
   localparam int DP = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   vc_writeback_buffer_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

   vc_writeback_buffer #(.DEPTH(DP), .ADDR_W(AW), .LINE_W(LW)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct packed {
      logic [31:0]  a;
      logic [255:0] d;
   } ent_t;

   ent_t mq[$];
   bit   busy;
   int   beat;
   bit   last_alloc;

   int vectors = 0;
   int errors  = 0;

   logic [31:0]  bursts[$];
   logic [63:0]  bdata[$];
   bit           pw_prev;

   task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [255:0] rnd_line();
      logic [255:0] l;
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
      return l;
   endfunction

   task automatic model_reset();
      mq.delete();
      busy = 0;
      beat = 0;
      last_alloc = 0;
   endtask

   // Apply one clock edge of the spec's rules to the queue model.
   task automatic model_step();
      int  n0;
      int  ci;
      bit  pop;
      ent_t e;
      last_alloc = 0;
      if (rst) begin
         model_reset();
         return;
      end
      n0  = mq.size();
      pop = busy && bus.pmem_resp && beat == 3;
      ci  = -1;
`ifdef VC_WB_COALESCE_EN
      if (bus.wb_push)
         for (int i = (busy ? 1 : 0); i < n0; i++)
            if (mq[i].a[31:5] == bus.wb_addr[31:5]) ci = i;
`endif
      if (bus.wb_push && ci >= 0) begin
         e = mq[ci];
         e.d = bus.wb_line;
         mq[ci] = e;
      end
      if (busy) begin
         if (bus.pmem_resp) begin
            if (beat == 3) busy = 0;
            else beat++;
         end
      end else if (n0 > 0 && !bus.drain_hold) begin
         busy = 1;
         beat = 0;
      end
      if (pop) void'(mq.pop_front());
      if (bus.wb_push && ci < 0 && n0 < DP) begin
         e.a = bus.wb_addr;
         e.d = bus.wb_line;
         mq.push_back(e);
         last_alloc = 1;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
   endtask

   // Compare every DUT output against the model on each falling edge.
   always @(negedge clk) begin
      int           n;
      bit           eh;
      logic [255:0] el;
      if (rst) begin
         pw_prev = 0;
      end else begin
         n  = mq.size();
         eh = 0;
         el = '0;
         for (int i = 0; i < n; i++)
            if (mq[i].a[31:5] == bus.lk_addr[31:5]) begin
               eh = 1;
               el = mq[i].d;
            end
         chk("wb_full", bus.wb_full, n == DP);
         chk("wb_empty", bus.wb_empty, n == 0);
         chk("pmem_write", bus.pmem_write, busy);
         chk("pmem_address", bus.pmem_address,
             busy ? {mq[0].a[31:5], 5'd0} : 32'd0);
         chk("pmem_wdata", bus.pmem_wdata,
             busy ? mq[0].d[beat*64 +: 64] : 64'd0);
         chk("lk_hit", bus.lk_hit, eh);
         chk("lk_line", bus.lk_line, el);
         if (bus.pmem_write && !pw_prev) begin
            bursts.push_back(bus.pmem_address);
            bdata.push_back(bus.pmem_wdata);
         end
         pw_prev = bus.pmem_write;
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      bus.wb_push    = 0;
      bus.wb_addr    = '0;
      bus.wb_line    = '0;
      bus.lk_addr    = '0;
      bus.drain_hold = 0;
      bus.pmem_resp  = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      bursts.delete();
      bdata.delete();
   endtask

   task automatic push_one(logic [31:0] a, logic [255:0] d);
      bus.wb_push = 1;
      bus.wb_addr = a;
      bus.wb_line = d;
      step();
      bus.wb_push = 0;
   endtask

   task automatic wait_empty();
      bit done;
      done = 0;
      for (int i = 0; i < 200 && !done; i++) begin
         step();
         done = (mq.size() == 0) && !busy;
      end
      chk("drain_done", done, 1);
   endtask

   logic [255:0] d1, d2, l1;
   logic [31:0]  exp_a[$];

   initial begin
      model_reset();
      do_reset();
      @(negedge clk);
      chk("rst_empty", bus.wb_empty, 1);
      chk("rst_write", bus.pmem_write, 0);
      chk("rst_hit", bus.lk_hit, 0);

      // Basic drain
      l1 = {64'h4, 64'h3, 64'h2, 64'h1};
      bus.pmem_resp = 1;
      push_one(32'h100, l1);
      @(negedge clk);
      chk("t1_write_idle", bus.pmem_write, 0);
      step();
      @(negedge clk);
      chk("t1_write", bus.pmem_write, 1);
      chk("t1_addr", bus.pmem_address, 32'h100);
      chk("t1_beat1", bus.pmem_wdata, 64'h1);
      for (int b = 2; b <= 4; b++) begin
         step();
         @(negedge clk);
         chk("t1_beat", bus.pmem_wdata, 64'(b));
      end
      step();
      @(negedge clk);
      chk("t1_empty", bus.wb_empty, 1);
      chk("t1_write_end", bus.pmem_write, 0);

      // Full and wrap-around
      do_reset();
      bus.drain_hold = 1;
      bus.pmem_resp  = 1;
      for (int i = 1; i <= 4; i++) push_one(32'(i * 32), rnd_line());
      bus.wb_push = 1;
      bus.wb_addr = 32'hA0;
      bus.wb_line = rnd_line();
      bus.lk_addr = 32'hA0;
      step();
      @(negedge clk);
      chk("t2_full", bus.wb_full, 1);
      chk("t2_ignored", bus.lk_hit, 0);
      bus.drain_hold = 0;
      for (int i = 0; i < 200 && !(mq.size() == 0 && !busy && !bus.wb_push); i++) begin
         step();
         if (last_alloc) bus.wb_push = 0;
      end
      chk("t2_pushed", bus.wb_push, 0);
      wait_empty();
      exp_a = '{32'h20, 32'h40, 32'h60, 32'h80, 32'hA0};
      chk("t2_nbursts", bursts.size(), 5);
      for (int i = 0; i < 5 && i < bursts.size(); i++)
         chk("t2_order", bursts[i], exp_a[i]);

      // Forwarding
      do_reset();
      bus.drain_hold = 1;
      d1 = rnd_line();
      push_one(32'h40, d1);
      bus.lk_addr = 32'h5F;
      @(negedge clk);
      chk("t3_hit", bus.lk_hit, 1);
      chk("t3_line", bus.lk_line, d1);
      #1 bus.lk_addr = 32'h60;
      #1;
      chk("t3_miss", bus.lk_hit, 0);
      chk("t3_miss_line", bus.lk_line, 256'd0);
      bus.drain_hold = 0;
      bus.pmem_resp  = 1;
      bus.lk_addr    = 32'h40;
      wait_empty();
      @(negedge clk);
      chk("t3_gone", bus.lk_hit, 0);

      // Duplicate address
      do_reset();
      bus.drain_hold = 1;
      d1 = rnd_line();
      d2 = rnd_line();
      push_one(32'h40, d1);
      push_one(32'h40, d2);
      bus.lk_addr = 32'h40;
      @(negedge clk);
      chk("t4_fwd", bus.lk_line, d2);
      bus.drain_hold = 0;
      bus.pmem_resp  = 1;
      wait_empty();
`ifdef VC_WB_COALESCE_EN
      chk("t4_nbursts", bursts.size(), 1);
`else
      chk("t4_nbursts", bursts.size(), 2);
`endif
      if (bdata.size() > 0)
         chk("t4_data", bdata[bdata.size()-1], d2[63:0]);

      // Mid-burst reset
      do_reset();
      bus.pmem_resp = 1;
      push_one(32'h300, rnd_line());
      step();
      step();
      rst = 1'b1;
      model_reset();
      #1;
      chk("t5_write", bus.pmem_write, 0);
      chk("t5_empty", bus.wb_empty, 1);
      repeat (2) step();
      rst = 1'b0;
      repeat (3) step();
      @(negedge clk);
      chk("t5_nobeat", bus.pmem_write, 0);

      // Push concurrent with final pop at count 2
      do_reset();
      bus.drain_hold = 1;
      push_one(32'h200, rnd_line());
      push_one(32'h300, rnd_line());
      bus.drain_hold = 0;
      step();
      bus.pmem_resp = 1;
      repeat (3) step();
      push_one(32'h400, rnd_line());
      bus.pmem_resp = 0;
      bus.lk_addr = 32'h200;
      @(negedge clk);
      chk("t6_popped", bus.lk_hit, 0);
      #1 bus.lk_addr = 32'h400;
      #1;
      chk("t6_newest", bus.lk_hit, 1);
      chk("t6_full", bus.wb_full, 0);
      bus.pmem_resp = 1;
      wait_empty();
      exp_a = '{32'h200, 32'h300, 32'h400};
      chk("t6_nbursts", bursts.size(), 3);
      for (int i = 0; i < 3 && i < bursts.size(); i++)
         chk("t6_order", bursts[i], exp_a[i]);

      // Randomized traffic
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 999) == 0) begin
            rst = 1'b1;
            model_reset();
            #1;
            chk("rnd_async_rst", bus.pmem_write, 0);
            step();
            rst = 1'b0;
         end
         bus.wb_push    = ($urandom_range(0, 1) == 1);
         bus.wb_addr    = ($urandom_range(0, 7) << 5) | $urandom_range(0, 31);
         bus.wb_line    = rnd_line();
         bus.lk_addr    = ($urandom_range(0, 7) << 5) | $urandom_range(0, 31);
         bus.drain_hold = ($urandom_range(0, 9) < 3);
         bus.pmem_resp  = ($urandom_range(0, 9) < 6);
         step();
      end
      bus.wb_push = 0;
      bus.pmem_resp = 1;
      wait_empty();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
